clock_divider_prog: RTL and testbench
=====================================

// Module: clock_divider_prog
// PURPOSE
//   Runtime-programmable integer clock divider, the parametrised successor to the fixed /10 divider.
//   Derives a divided clock-enable waveform (o_clk) and a one-cycle o_tick pulse from the system clock.
//   The divide ratio is loaded via a valid/ready handshake and takes effect only at a period boundary,
//   so there are no runt pulses. Feeds baud, sampling and display-scan logic.
// PARAMETERS
//   CNT_W      16  width of divisor, high-time and internal counter (bits)
//   DIV_RESET  10  divisor active after reset (10 => 50 MHz to 5 MHz); must be >=2 and < 2**CNT_W
// PORTS
//   i_clk        in   1      system clock; all logic on posedge
//   i_rst        in   1      synchronous, active-high reset
//   i_en         in   1      run enable; low = hold idle
//   i_div        in   CNT_W  requested divisor N
//   i_div_valid  in   1      request valid
//   o_div_ready  out  1      request slot free; transfer when valid & ready
//   o_div_err    out  1      1-cycle pulse: accepted request was illegal and has been discarded
//   o_clk        out  1      divided waveform, registered
//   o_tick       out  1      1-cycle pulse coincident with each o_clk rising edge
// BEHAVIOUR
//   Reset (i_rst=1 at a posedge), applied next cycle:
//   - o_clk=0, o_tick=0, o_div_err=0, o_div_ready=1
//   - active N=DIV_RESET, counter=0, pending request discarded
//   - Reset mid-period or mid-handshake aborts everything; no partial state survives.
//   Waveform: high time H = N - (N>>1) (ceil(N/2)), low time N-H. Period is exactly N cycles.
//   Enable:
//   - If i_en is first sampled high at edge k: o_clk high in cycles k+1..k+H, low in k+H+1..k+N, repeating.
//   - o_tick=1 in cycles k+1, k+1+N, k+1+2N, ... Latency from enable to first tick = 1 cycle.
//   - i_en sampled low: next cycle o_clk=0, o_tick=0, counter=0. Re-enable restarts a full period.
//   Counter r_count counts 0..N-1 and wraps to 0 (wrap cycle = tick cycle). No overflow: N < 2**CNT_W.
//   Load handshake:
//   - On valid & ready, capture i_div into the pending register; o_div_ready=0 the next cycle.
//   - While pending: if running, apply at the next wrap (the first tick of the new period uses the new N).
//   - While pending: if i_en=0, apply on the following cycle.
//   - After applying, o_div_ready=1 the cycle after the apply.
//   - Accept on the same cycle as a wrap: the wrap uses the old N; the new N applies at the following wrap.
//   - i_div_valid with o_div_ready=0: not accepted; the requester must hold it.
//   - Illegal N (0 or 1): the request is accepted, discarded, o_div_err=1 next cycle, active N unchanged.
//     o_div_ready stays 1.
//   Idle (i_en low) holds the active N and the pending request; only reset clears them.
// CONFIGURATION
//   `CLKDIV_DUTY_EN defined:
//   - Adds port i_high (in, CNT_W), captured with i_div; H = i_high.
//   - Legal iff 2<=N and 1<=H<=N-1, otherwise the o_div_err path applies.
//   - Reset H = DIV_RESET - (DIV_RESET>>1).
//   `CLKDIV_DUTY_EN undefined:
//   - No i_high port; H is always ceil(N/2).
// TESTING
//   1 reset, i_en=1, no load -> o_clk 5 high/5 low, o_tick every 10 cycles, first tick 1 cycle after enable
//   2 load N=3 at cycle 4 of a period -> period completes at 10, then 2 high/1 low; o_div_ready low until apply
//   3 load N=1 -> o_div_err pulse 1 cycle later, period stays 10, o_div_ready never drops
//   4 drop i_en mid-high phase -> o_clk=0 next cycle; re-enable -> fresh 5/5 period, tick 1 cycle later
//   5 second valid while pending -> not accepted until ready; assert i_rst mid-period -> all outputs reset next cycle, N=10
//   6 (`CLKDIV_DUTY_EN) N=8, H=1 -> 1 high/7 low; N=4, H=4 -> o_div_err, waveform unchanged

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider producing a registered o_clk waveform and o_tick pulse.
// Define CLKDIV_DUTY_EN to add the i_high port for a programmable high time.
module clock_divider_prog #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_div_valid,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0] i_high,
`endif
    output logic             o_div_ready,
    output logic             o_div_err,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DIV_RESET - (DIV_RESET >> 1));

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pend_q, pend_d;
    logic             run_q;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] req_high;
    logic             req_legal;
    logic             accept;
    logic             wrap;
    logic             boundary;
    logic             apply;

`ifdef CLKDIV_DUTY_EN
    assign req_high  = i_high;
    assign req_legal = (i_div >= CNT_W'(2)) && (i_high >= CNT_W'(1))
                       && (i_high <= i_div - CNT_W'(1));
`else
    assign req_high  = i_div - (i_div >> 1);
    assign req_legal = (i_div >= CNT_W'(2));
`endif

    // A period boundary is the start of a run, the wrap of a running period, or idle.
    assign accept   = i_div_valid && !pend_q;
    assign wrap     = run_q && (count_q == div_q - CNT_W'(1));
    assign boundary = !i_en || !run_q || wrap;
    assign apply    = pend_q && boundary;

    always_comb begin
        div_d       = div_q;
        high_d      = high_q;
        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        err_d       = 1'b0;
        count_d     = boundary ? '0 : count_q + CNT_W'(1);

        if (apply) begin
            div_d  = pend_div_q;
            high_d = pend_high_q;
            pend_d = 1'b0;
        end else if (accept) begin
            if (req_legal) begin
                pend_d      = 1'b1;
                pend_div_d  = i_div;
                pend_high_d = req_high;
            end else begin
                err_d = 1'b1;
            end
        end

        clk_d  = i_en && (count_d < high_d);
        tick_d = i_en && (count_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q     <= '0;
            div_q       <= DIV_RST;
            high_q      <= HIGH_RST;
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            pend_high_q <= '0;
            run_q       <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            run_q       <= i_en;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
        end
    end

    assign o_div_ready = !pend_q;
    assign o_div_err   = err_q;
    assign o_clk       = clk_q;
    assign o_tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: expected {err, ready, tick, clk} per cycle is queued
// when the stimulus is driven and popped when the cycle's outputs are sampled on the falling edge.
module tb_clock_divider_prog;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_valid;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic             div_ready;
    logic             div_err;
    logic             o_clk;
    logic             tick;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] got_v;

    always #5 clk = ~clk;

    clock_divider_prog #(.CNT_W(CNT_W), .DIV_RESET(10)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_div       (div),
        .i_div_valid (div_valid),
`ifdef CLKDIV_DUTY_EN
        .i_high      (high),
`endif
        .o_div_ready (div_ready),
        .o_div_err   (div_err),
        .o_clk       (o_clk),
        .o_tick      (tick)
    );

    // Expected {tick, clk} at position m of a period of n cycles with h high cycles.
    function automatic logic [1:0] wave(input int m, input int n, input int h);
        int p;
        p = m % n;
        return {p == 0, p < h};
    endfunction

    task automatic set_in(input logic e, input logic r, input logic v, input int n);
        en        = e;
        rst       = r;
        div_valid = v;
        div       = CNT_W'(n);
        high      = CNT_W'(n - n / 2);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b1, 1'b0, 0);
        step();
        step();
        set_in(1'b0, 1'b0, 1'b0, 0);
        step();
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            set_in(j == 1, 1'b1, j == 2, 3);
            exp_q.push_back(4'b0100);
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%b exp=%b (err,rdy,tick,clk)", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_default();
        do_reset();
        for (int j = 0; j < 30; j++) begin
            set_in(1'b1, 1'b0, 1'b0, 0);
            exp_q.push_back({2'b01, wave(j, 10, 5)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL default_div10 cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_load_running();
        do_reset();
        for (int j = 0; j < 25; j++) begin
            set_in(1'b1, 1'b0, j == 4, 3);
            if (j < 10) exp_q.push_back({1'b0, j < 4, wave(j, 10, 5)});
            else        exp_q.push_back({2'b01, wave(j - 10, 3, 2)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL load_n3 cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int j = 0; j < 30; j++) begin
            set_in(1'b1, 1'b0, (j == 4) || (j == 14), (j == 4) ? 1 : 0);
            exp_q.push_back({(j == 4) || (j == 14), 1'b1, wave(j, 10, 5)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL illegal_div cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int j = 0; j < 20; j++) begin
            set_in(!(j >= 3 && j <= 5), 1'b0, 1'b0, 0);
            if (j < 3)      exp_q.push_back({2'b01, wave(j, 10, 5)});
            else if (j < 6) exp_q.push_back(4'b0100);
            else            exp_q.push_back({2'b01, wave(j - 6, 10, 5)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL enable_drop cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_idle_load();
        do_reset();
        for (int j = 0; j < 14; j++) begin
            set_in(j >= 4, 1'b0, j == 1, 4);
            if (j < 4) exp_q.push_back({1'b0, j != 1, 2'b00});
            else       exp_q.push_back({2'b01, wave(j - 4, 4, 2)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL idle_load cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_accept_at_wrap();
        do_reset();
        for (int j = 0; j < 30; j++) begin
            set_in(1'b1, 1'b0, j == 10, 4);
            if (j < 10)      exp_q.push_back({2'b01, wave(j, 10, 5)});
            else if (j < 20) exp_q.push_back({2'b00, wave(j - 10, 10, 5)});
            else             exp_q.push_back({2'b01, wave(j - 20, 4, 2)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL accept_at_wrap cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 43; j++) begin
            set_in(1'b1, j == 22, (j >= 2) && (j <= 11), (j == 2) ? 4 : 6);
            if (j < 2)       exp_q.push_back({2'b01, wave(j, 10, 5)});
            else if (j < 10) exp_q.push_back({2'b00, wave(j, 10, 5)});
            else if (j < 11) exp_q.push_back({2'b01, wave(0, 4, 2)});
            else if (j < 14) exp_q.push_back({2'b00, wave(j - 10, 4, 2)});
            else if (j < 22) exp_q.push_back({2'b01, wave(j - 14, 6, 3)});
            else if (j < 23) exp_q.push_back(4'b0100);
            else             exp_q.push_back({2'b01, wave(j - 23, 10, 5)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL back_to_back_reset cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask

`ifdef CLKDIV_DUTY_EN
    task automatic test_duty();
        do_reset();
        for (int j = 0; j < 30; j++) begin
            set_in(1'b1, 1'b0, (j == 2) || (j == 20), (j == 2) ? 8 : 4);
            high = (j == 2) ? CNT_W'(1) : CNT_W'(4);
            if (j < 2)       exp_q.push_back({2'b01, wave(j, 10, 5)});
            else if (j < 10) exp_q.push_back({2'b00, wave(j, 10, 5)});
            else             exp_q.push_back({j == 20, 1'b1, wave(j - 10, 8, 1)});
            step();
            exp_v = exp_q.pop_front();
            got_v = {div_err, div_ready, tick, o_clk};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL duty cyc=%0d got=%b exp=%b", j, got_v, exp_v);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        test_reset();
        test_default();
        test_load_running();
        test_illegal();
        test_enable_drop();
        test_idle_load();
        test_accept_at_wrap();
        test_back_to_back();
`ifdef CLKDIV_DUTY_EN
        test_duty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
